// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit adder sequencer driving one external 4-bit combinational adder slice, LSB nibble first.
// Optional macro SERIAL_ADD_OVF_EN adds a registered signed-overflow output (ovf).
module nibble_serial_add_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             busy,
    output logic [3:0]       add_x,
    output logic [3:0]       add_y,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    generate
        if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_chk
            $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Next-state, slice drive and handshake decode
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d     = ovf_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        add_x     = 4'h0;
        add_y     = 4'h0;
        add_cin   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    carry_d  = c_in;
                    idx_d    = '0;
                    result_d = '0;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d    = 1'b0;
`endif
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                busy    = 1'b1;
                add_x   = a_q[4*idx_q +: 4];
                add_y   = b_q[4*idx_q +: 4];
                add_cin = carry_q;
                result_d[4*idx_q +: 4] = add_sum;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
                    idx_d   = '0;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[3] != a_q[WIDTH-1]);
`endif
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign result = result_q;
    assign c_out  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule
